// File: rtl/br_lite_inject_arbiter_pkg.sv
// rtl/br_lite_inject_arbiter_pkg.sv - BrLite shared types for the local injection arbiter
package BrLitePkg;

    localparam int BR_DATA_W = 32;

    typedef logic [BR_DATA_W-1:0] br_data_t;

    typedef enum logic [1:0] {
        BR_ARB_IDLE,
        BR_ARB_SEND,
        BR_ARB_GAP
    } br_arb_state_t;

    // Index/counter width that never collapses to zero bits.
    function automatic int br_clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/br_lite_inject_arbiter_if.sv
// rtl/br_lite_inject_arbiter_if.sv - source-side and router-side signals of the injection arbiter
interface br_lite_inject_arbiter_if #(
    parameter int N_SRC = 4
);
    import BrLitePkg::*;

    localparam int IDW = br_clog2_min1(N_SRC);

    br_data_t [N_SRC-1:0] src_flit_i;
    logic     [N_SRC-1:0] src_req_i;
    logic     [N_SRC-1:0] src_ack_o;
    br_data_t             flit_o;
    logic                 req_o;
    logic                 ack_i;
    logic                 busy_i;
    logic     [IDW-1:0]   grant_id_o;
    logic                 active_o;
    logic     [31:0]      inject_cnt_o;

    modport master (
        input  src_flit_i, src_req_i, ack_i, busy_i,
        output src_ack_o, flit_o, req_o, grant_id_o, active_o, inject_cnt_o
    );

    modport slave (
        output src_flit_i, src_req_i, ack_i, busy_i,
        input  src_ack_o, flit_o, req_o, grant_id_o, active_o, inject_cnt_o
    );

endinterface

// File: rtl/br_lite_inject_arbiter_rr.sv
// rtl/br_lite_inject_arbiter_rr.sv - combinational round-robin pick starting after ptr
module br_rr_arbiter
    import BrLitePkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]                  req,
    input  logic [br_clog2_min1(N)-1:0]   ptr,
    output logic [N-1:0]                  gnt,
    output logic [br_clog2_min1(N)-1:0]   idx,
    output logic                          valid
);

    localparam int W = br_clog2_min1(N);

    // Search offsets 1..N so the pointer itself has lowest priority; mod N keeps non-power-of-two N correct.
    always_comb begin
        int cand;
        gnt   = '0;
        idx   = '0;
        valid = 1'b0;
        cand  = 0;
        for (int k = 1; k <= N; k++) begin
            cand = (int'(ptr) + k) % N;
            if (!valid && req[cand]) begin
                valid = 1'b1;
                idx   = W'(cand);
            end
        end
        if (valid) begin
            gnt[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/br_lite_inject_arbiter.sv
// rtl/br_lite_inject_arbiter.sv - round-robin sharing of the BrLite local injection port
module br_lite_inject_arbiter
    import BrLitePkg::*;
#(
    parameter int N_SRC      = 4,
    parameter int GAP_CYCLES = 0
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    br_lite_inject_arbiter_if.master bus
);

    localparam int              IDW        = br_clog2_min1(N_SRC);
    localparam int              GW         = br_clog2_min1(GAP_CYCLES + 1);
    localparam int              GAP_LOAD_I = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
    localparam logic [GW-1:0]   GAP_LOAD   = GW'(GAP_LOAD_I);
    localparam logic [IDW-1:0]  PTR_RST    = IDW'(N_SRC - 1);

    br_arb_state_t    state_q, state_d;
    logic [GW-1:0]    gap_q, gap_d;
    logic [IDW-1:0]   ptr_q;
    logic [N_SRC-1:0] ack_q;
    br_data_t         flit_q;
    logic [31:0]      cnt_q;

    logic [N_SRC-1:0] pick_gnt;
    logic [IDW-1:0]   pick_idx;
    logic             pick_valid;
    logic             grant_fire;
    logic             inject_done;

    br_rr_arbiter #(.N(N_SRC)) u_rr (
        .req   (bus.src_req_i),
        .ptr   (ptr_q),
        .gnt   (pick_gnt),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    always_comb begin
        state_d     = state_q;
        gap_d       = gap_q;
        grant_fire  = 1'b0;
        inject_done = 1'b0;
        case (state_q)
            BR_ARB_IDLE: begin
                if (!bus.busy_i && pick_valid) begin
                    grant_fire = 1'b1;
                    state_d    = BR_ARB_SEND;
                end
            end
            BR_ARB_SEND: begin
                if (bus.ack_i) begin
                    inject_done = 1'b1;
                    gap_d       = GAP_LOAD;
                    state_d     = (GAP_CYCLES > 0) ? BR_ARB_GAP : BR_ARB_IDLE;
                end
            end
            BR_ARB_GAP: begin
                if (gap_q == '0) begin
                    state_d = BR_ARB_IDLE;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            default: state_d = BR_ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= BR_ARB_IDLE;
            gap_q   <= '0;
            ptr_q   <= PTR_RST;
            ack_q   <= '0;
            flit_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
            ack_q   <= grant_fire ? pick_gnt : '0;
            if (grant_fire) begin
                ptr_q  <= pick_idx;
                flit_q <= bus.src_flit_i[pick_idx];
            end
            if (inject_done) begin
                cnt_q <= cnt_q + 32'd1;
            end
        end
    end

    // Router-facing req/active decode straight from the state flop, so reset drops them at once.
    assign bus.src_ack_o    = ack_q;
    assign bus.flit_o       = flit_q;
    assign bus.req_o        = (state_q == BR_ARB_SEND);
    assign bus.grant_id_o   = ptr_q;
    assign bus.active_o     = (state_q != BR_ARB_IDLE);
    assign bus.inject_cnt_o = cnt_q;

endmodule
